// File: rtl/cordic_req_arbiter.sv
// Round-robin front end that shares one cordic_top among NUM_REQ requesters.
// Owner tags of in-flight operations are queued in issue order so each core
// result can be steered back to the requester that issued it.
module cordic_req_arbiter #(
   parameter int unsigned NUM_REQ         = 4,
   parameter int unsigned TOTAL_WIDTH     = 49,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic [NUM_REQ-1:0]               i_req_vld,
   input  logic [NUM_REQ*TOTAL_WIDTH-1:0]   i_req_data,
   output logic [NUM_REQ-1:0]               o_req_rdy,
   output logic                             o_core_vld,
   output logic [TOTAL_WIDTH-1:0]           o_core_data,
   input  logic                             i_core_vld,
   input  logic [TOTAL_WIDTH-1:0]           i_core_data,
   output logic [NUM_REQ-1:0]               o_rsp_vld,
   output logic [TOTAL_WIDTH-1:0]           o_rsp_data,
   output logic [$clog2(MAX_OUTSTANDING):0] o_inflight,
   output logic                             o_err
);

   localparam int unsigned TAG_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [TAG_W-1:0] LAST_REQ = TAG_W'(NUM_REQ - 1);

   // Tag FIFO: owner of every operation currently inside the core
   logic [TAG_W-1:0]       r_tag_fifo [MAX_OUTSTANDING];
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [CNT_W-1:0]       r_inflight;

   logic [TAG_W-1:0]       r_rr_ptr;
   logic                   r_core_vld;
   logic [TOTAL_WIDTH-1:0] r_core_data;
   logic [NUM_REQ-1:0]     r_rsp_vld;
   logic [TOTAL_WIDTH-1:0] r_rsp_data;
   logic                   r_err;

   logic                   w_empty;
   logic                   w_pop;
   logic                   w_spurious;
   logic                   w_can_issue;
   logic                   w_found;
   logic [TAG_W-1:0]       w_winner;
   logic [TOTAL_WIDTH-1:0] w_win_data;
   logic                   w_push;
   logic [NUM_REQ-1:0]     w_rdy;
   logic [TAG_W-1:0]       w_pop_tag;

   // Inflight count doubles as FIFO occupancy, so empty is simply zero in flight
   assign w_empty     = (r_inflight == '0);
   assign w_pop       = i_core_vld && !w_empty;
   assign w_spurious  = i_core_vld && w_empty;
   // A pop in this cycle frees the slot the new push will take
   assign w_can_issue = (r_inflight < MAX_CNT) || w_pop;
   assign w_pop_tag   = r_tag_fifo[r_rd_ptr];

   // Round-robin pick: first requester at or above rr_ptr, then wrap from 0
   always_comb begin
      w_found    = 1'b0;
      w_winner   = '0;
      w_win_data = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!w_found && i_req_vld[j] && (TAG_W'(j) >= r_rr_ptr)) begin
            w_found    = 1'b1;
            w_winner   = TAG_W'(j);
            w_win_data = i_req_data[j*TOTAL_WIDTH +: TOTAL_WIDTH];
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!w_found && i_req_vld[j]) begin
            w_found    = 1'b1;
            w_winner   = TAG_W'(j);
            w_win_data = i_req_data[j*TOTAL_WIDTH +: TOTAL_WIDTH];
         end
      end
   end

   // Grant the winner whenever a credit is available
   always_comb begin
      w_rdy = '0;
      if (w_found && w_can_issue) begin
         w_rdy = NUM_REQ'(1) << w_winner;
      end
   end

   assign w_push    = w_found && w_can_issue;
   assign o_req_rdy = w_rdy;

   // Tag storage; contents are meaningless while the pointers say empty
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_tag_fifo[r_wr_ptr] <= w_winner;
      end
   end

   // FIFO pointers and inflight count
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_inflight <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_inflight <= r_inflight + 1'b1;
         end else if (w_pop && !w_push) begin
            r_inflight <= r_inflight - 1'b1;
         end
      end
   end

   // Issue path: registered request to the core and round-robin advance
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_core_vld  <= 1'b0;
         r_core_data <= '0;
         r_rr_ptr    <= '0;
      end else begin
         r_core_vld <= w_push;
         if (w_push) begin
            r_core_data <= w_win_data;
            r_rr_ptr    <= (w_winner == LAST_REQ) ? '0 : w_winner + 1'b1;
         end
      end
   end

   // Return path: steer core result to its owner; flag results with no owner
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rsp_vld  <= '0;
         r_rsp_data <= '0;
         r_err      <= 1'b0;
      end else begin
         r_rsp_vld <= w_pop ? (NUM_REQ'(1) << w_pop_tag) : '0;
         if (w_pop) begin
            r_rsp_data <= i_core_data;
         end
         if (w_spurious) begin
            r_err <= 1'b1;
         end
      end
   end

   assign o_core_vld  = r_core_vld;
   assign o_core_data = r_core_data;
   assign o_rsp_vld   = r_rsp_vld;
   assign o_rsp_data  = r_rsp_data;
   assign o_inflight  = r_inflight;
   assign o_err       = r_err;

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Bench for cordic_req_arbiter: a stub core, a queue-based reference model,
// a per-requester routing scoreboard, a vector table and directed sequences.
module tb_cordic_req_arbiter;

   localparam int N    = 4;
   localparam int W    = 49;
   localparam int MAXO = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_vld;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_rdy;
   logic           core_vld_o;
   logic [W-1:0]   core_data_o;
   logic           core_vld;
   logic [W-1:0]   core_data;
   logic [N-1:0]   rsp_vld;
   logic [W-1:0]   rsp_data;
   logic [2:0]     inflight;
   logic           err;

   always #5 clk = ~clk;

   cordic_req_arbiter #(
      .NUM_REQ        (N),
      .TOTAL_WIDTH    (W),
      .MAX_OUTSTANDING(MAXO)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_req_vld  (req_vld),
      .i_req_data (req_data),
      .o_req_rdy  (req_rdy),
      .o_core_vld (core_vld_o),
      .o_core_data(core_data_o),
      .i_core_vld (core_vld),
      .i_core_data(core_data),
      .o_rsp_vld  (rsp_vld),
      .o_rsp_data (rsp_data),
      .o_inflight (inflight),
      .o_err      (err)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Reference model: owners in issue order plus registered-output expectations
   int           m_q[$];
   int           m_rr;
   bit           m_err;
   bit           m_core_vld;
   logic [W-1:0] m_core_data;
   logic [N-1:0] m_rsp_vld;
   logic [W-1:0] m_rsp_data;
   int           last_xfer;

   // Snapshot of DUT outputs taken at the falling edge of the last cycle
   logic [N-1:0] s_rdy;
   logic         s_core_vld;
   logic [W-1:0] s_core_data;
   logic [N-1:0] s_rsp_vld;
   logic [W-1:0] s_rsp_data;
   logic [2:0]   s_inflight;
   logic         s_err;

   // Stub core and routing scoreboard
   bit           stub_auto;
   bit           rand_lat;
   int           fix_lat;
   int           last_due;
   logic [W-1:0] ret_data_q[$];
   int           ret_due_q[$];
   bit           sb_en;
   logic [W-1:0] sent_q[N][$];
   bit           pend[N];

   typedef struct {
      logic [N-1:0] vld;
      logic [N-1:0] exp_rdy;
   } vec_t;
   vec_t tbl[12];

   function automatic logic [W-1:0] core_fn(input logic [W-1:0] d);
      return {d[0], d[W-1:1]} ^ 49'h0_A5A5_5A5A_0F0F;
   endfunction

   function automatic logic [W-1:0] rand_data();
      logic [63:0] t;
      t = {$urandom, $urandom};
      return t[W-1:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_rr        = 0;
      m_err       = 0;
      m_core_vld  = 0;
      m_core_data = '0;
      m_rsp_vld   = '0;
      m_rsp_data  = '0;
      last_xfer   = -1;
      ret_data_q.delete();
      ret_due_q.delete();
      last_due = cyc;
      for (int r = 0; r < N; r++) sent_q[r].delete();
   endtask

   task automatic stub_drive();
      if (stub_auto) begin
         if (ret_due_q.size() > 0 && ret_due_q[0] == cyc) begin
            core_vld  = 1'b1;
            core_data = ret_data_q.pop_front();
            void'(ret_due_q.pop_front());
         end else begin
            core_vld  = 1'b0;
            core_data = rand_data();
         end
      end
   endtask

   task automatic model_step();
      int sz, win, r, owner, due;
      bit can;
      logic [N-1:0] exp_rdy;
      s_rdy       = req_rdy;
      s_core_vld  = core_vld_o;
      s_core_data = core_data_o;
      s_rsp_vld   = rsp_vld;
      s_rsp_data  = rsp_data;
      s_inflight  = inflight;
      s_err       = err;
      sz  = m_q.size();
      can = (sz < MAXO) || (core_vld && sz > 0);
      win = -1;
      for (int k = 0; k < N; k++) begin
         r = (m_rr + k) % N;
         if (win < 0 && req_vld[r]) win = r;
      end
      exp_rdy = (win >= 0 && can) ? (N'(1) << win) : '0;
      chk("rdy", s_rdy, exp_rdy);
      chk("core_vld", s_core_vld, m_core_vld);
      chk("core_data", s_core_data, m_core_data);
      chk("rsp_vld", s_rsp_vld, m_rsp_vld);
      if (m_rsp_vld != '0) chk("rsp_data", s_rsp_data, m_rsp_data);
      chk("inflight", s_inflight, sz);
      chk("err", s_err, m_err);
      if (sb_en && s_rsp_vld != '0) begin
         owner = 0;
         for (int k = 0; k < N; k++) if (s_rsp_vld[k]) owner = k;
         chk("route_pending", sent_q[owner].size() > 0, 1);
         if (sent_q[owner].size() > 0) chk("route_data", s_rsp_data, core_fn(sent_q[owner].pop_front()));
      end
      // Advance model state across the coming edge
      m_rsp_vld = '0;
      if (core_vld) begin
         if (sz > 0) begin
            owner      = m_q.pop_front();
            m_rsp_vld  = N'(1) << owner;
            m_rsp_data = core_data;
         end else begin
            m_err = 1;
         end
      end
      if (win >= 0 && can) begin
         m_q.push_back(win);
         m_core_vld  = 1;
         m_core_data = req_data[win*W +: W];
         m_rr        = (win + 1) % N;
         last_xfer   = win;
         if (sb_en) sent_q[win].push_back(m_core_data);
      end else begin
         m_core_vld = 0;
         last_xfer  = -1;
      end
      if (stub_auto && s_core_vld) begin
         due = cyc + (rand_lat ? int'($urandom_range(1, 6)) : fix_lat);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         ret_due_q.push_back(due);
         ret_data_q.push_back(core_fn(s_core_data));
      end
   endtask

   task automatic cycle();
      stub_drive();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_vld   = '0;
      core_vld  = 1'b0;
      core_data = '0;
      stub_auto = 0;
      sb_en     = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic drain(input int n);
      req_vld = '0;
      repeat (n) cycle();
   endtask

   initial begin
      int exp_next;
      req_data = '0;
      tbl[0]  = '{4'b0000, 4'b0000};
      tbl[1]  = '{4'b0100, 4'b0100};
      tbl[2]  = '{4'b0011, 4'b0001};
      tbl[3]  = '{4'b0011, 4'b0010};
      tbl[4]  = '{4'b1001, 4'b1000};
      tbl[5]  = '{4'b1111, 4'b0001};
      tbl[6]  = '{4'b1101, 4'b0100};
      tbl[7]  = '{4'b1000, 4'b1000};
      tbl[8]  = '{4'b0110, 4'b0010};
      tbl[9]  = '{4'b0000, 4'b0000};
      tbl[10] = '{4'b0010, 4'b0010};
      tbl[11] = '{4'b0101, 4'b0100};

      // Reset state
      do_reset();
      chk("rst_core_vld", core_vld_o, 0);
      chk("rst_core_data", core_data_o, 0);
      chk("rst_rsp_vld", rsp_vld, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_err", err, 0);

      // Single request from requester 2
      req_vld  = 4'b0100;
      req_data[2*W +: W] = 49'h1_0000_0000_1234;
      cycle();
      chk("single_rdy", s_rdy, 4'b0100);
      req_vld = '0;
      cycle();
      chk("single_core_vld", s_core_vld, 1);
      chk("single_core_data", s_core_data, 49'h1_0000_0000_1234);
      core_vld  = 1'b1;
      core_data = 49'hABC;
      cycle();
      core_vld = 1'b0;
      cycle();
      chk("single_rsp_vld", s_rsp_vld, 4'b0100);
      chk("single_rsp_data", s_rsp_data, 49'hABC);

      // Vector table, core latency 2 so credit never runs out
      do_reset();
      stub_auto = 1; rand_lat = 0; fix_lat = 2; sb_en = 1;
      foreach (tbl[i]) begin
         req_vld = tbl[i].vld;
         for (int r = 0; r < N; r++) req_data[r*W +: W] = rand_data();
         cycle();
         chk("tbl_rdy", s_rdy, tbl[i].exp_rdy);
      end
      drain(6);

      // Fairness with all requesters asserting continuously
      do_reset();
      stub_auto = 1; rand_lat = 0; fix_lat = 2; sb_en = 1;
      for (int r = 0; r < N; r++) req_data[r*W +: W] = rand_data();
      req_vld  = '1;
      exp_next = 0;
      for (int i = 0; i < 16; i++) begin
         cycle();
         chk("fair_grant", last_xfer, exp_next);
         exp_next = (exp_next + 1) % N;
         if (last_xfer >= 0) req_data[last_xfer*W +: W] = rand_data();
      end
      drain(6);

      // Sustained push and pop at full credit (latency 3 keeps 4 in flight)
      do_reset();
      stub_auto = 1; rand_lat = 0; fix_lat = 3; sb_en = 1;
      req_vld = '1;
      for (int i = 0; i < 26; i++) begin
         cycle();
         if (i >= 6) begin
            chk("full_inflight", s_inflight, 4);
            chk("full_xfer", last_xfer >= 0, 1);
            chk("full_err", s_err, 0);
         end
         if (last_xfer >= 0) req_data[last_xfer*W +: W] = rand_data();
      end
      drain(8);

      // Credit limit with a core that never answers
      do_reset();
      req_vld = '1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("credit_rdy", s_rdy, 4'b0001 << i);
      end
      for (int i = 0; i < 2; i++) begin
         cycle();
         chk("credit_block_rdy", s_rdy, 0);
         chk("credit_inflight", s_inflight, 4);
      end
      core_vld  = 1'b1;
      core_data = 49'h123;
      cycle();
      chk("credit_pop_rdy", s_rdy, 4'b0001);
      core_vld = 1'b0;
      cycle();
      chk("credit_pop_inflight", s_inflight, 4);
      chk("credit_pop_rsp", s_rsp_vld, 4'b0001);
      chk("credit_pop_rdy_after", s_rdy, 0);

      // Spurious return with nothing in flight
      do_reset();
      core_vld  = 1'b1;
      core_data = rand_data();
      cycle();
      core_vld = 1'b0;
      cycle();
      chk("spur_err", s_err, 1);
      chk("spur_rsp_vld", s_rsp_vld, 0);
      chk("spur_inflight", s_inflight, 0);
      repeat (3) cycle();
      chk("spur_err_sticky", s_err, 1);

      // Reset with three operations in flight
      do_reset();
      for (int k = 0; k < 3; k++) begin
         req_vld = 4'b0001 << k;
         req_data[k*W +: W] = rand_data() | 49'h1;
         cycle();
      end
      req_vld  = 4'b1000;
      req_data[3*W +: W] = rand_data() | 49'h1;
      core_vld  = 1'b1;
      core_data = 49'h0_5555_0000_5555;
      cycle();
      chk("mid_pre_inflight", inflight, 3);
      chk("mid_pre_core_vld", core_vld_o, 1);
      chk("mid_pre_rsp_vld", rsp_vld, 4'b0001);
      core_vld = 1'b0;
      req_vld  = '0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_core_vld", core_vld_o, 0);
      chk("mid_core_data", core_data_o, 0);
      chk("mid_rsp_vld", rsp_vld, 0);
      chk("mid_rsp_data", rsp_data, 0);
      chk("mid_inflight", inflight, 0);
      chk("mid_err", err, 0);
      chk("mid_rdy", req_rdy, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      req_vld = 4'b0010;
      cycle();
      chk("post_rst_rdy", s_rdy, 4'b0010);
      chk("post_rst_inflight0", s_inflight, 0);
      req_vld = '0;
      cycle();
      chk("post_rst_inflight1", s_inflight, 1);

      // Randomised traffic with random in-order core latency
      do_reset();
      stub_auto = 1; rand_lat = 1; sb_en = 1;
      for (int r = 0; r < N; r++) pend[r] = 0;
      for (int i = 0; i < 600; i++) begin
         for (int r = 0; r < N; r++) begin
            if (!pend[r]) begin
               if ($urandom_range(0, 2) != 0) begin
                  pend[r] = 1;
                  req_data[r*W +: W] = rand_data();
               end
            end else if ($urandom_range(0, 15) == 0) begin
               pend[r] = 0;
            end
            req_vld[r] = pend[r];
         end
         cycle();
         if (last_xfer >= 0) pend[last_xfer] = 0;
      end
      drain(12);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cordic_req_arbiter.md
Name: cordic_req_arbiter

Overview:
- Shares one cordic_top instance among NUM_REQ independent requesters.
- Arbitrates by round-robin and issues at most one operation per cycle to the core.
- Tracks the owner of every in-flight operation in a tag FIFO and steers each core result back to that owner.
- Sits between the requester fabric and cordic_top. cordic_top carries no tag, so ordering is strictly in-order.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TOTAL_WIDTH, 49, operand/result width; must match cordic_top TOTAL_WIDTH.
- MAX_OUTSTANDING, 4, maximum operations in flight in the core; also the tag FIFO depth (power of 2, 2..16).
- TAG_W, derived localparam = max(1, clog2(NUM_REQ)).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_vld  in  NUM_REQ  per-requester request valid.
- i_req_data  in  NUM_REQ*TOTAL_WIDTH  request operands; requester r occupies bits [r*TOTAL_WIDTH +: TOTAL_WIDTH].
- o_req_rdy  out  NUM_REQ  per-requester accept, one-hot or zero.
- o_core_vld  out  1  to cordic_top i_vld.
- o_core_data  out  TOTAL_WIDTH  to cordic_top i_data.
- i_core_vld  in  1  from cordic_top o_vld.
- i_core_data  in  TOTAL_WIDTH  from cordic_top o_data.
- o_rsp_vld  out  NUM_REQ  one-hot result valid to the owning requester.
- o_rsp_data  out  TOTAL_WIDTH  result data, broadcast to all requesters.
- o_inflight  out  clog2(MAX_OUTSTANDING)+1  current in-flight count.
- o_err  out  1  sticky protocol error.

Behaviour:
- Reset (async assert, sync release): all of the following clear to 0:
  - o_core_vld, o_core_data, o_rsp_vld, o_rsp_data, o_inflight, o_err;
  - tag FIFO pointers;
  - round-robin pointer (requester 0 has highest priority first).
- cordic_top must be reset by the same event; the top level drives its i_rst = ~i_rst_n.
- Credit:
  - can_issue = (o_inflight < MAX_OUTSTANDING) OR (i_core_vld AND FIFO not empty).
  - A pop and a push in the same cycle at full is legal.
- Arbitration (combinational):
  - Among i_req_vld, pick the first set bit at or above rr_ptr, wrapping modulo NUM_REQ.
  - o_req_rdy[winner] = can_issue. All other rdy bits are 0.
  - o_req_rdy is not gated by anything else.
- Handshake:
  - Transfer occurs when i_req_vld[r] AND o_req_rdy[r].
  - A requester holds vld and data stable until accepted.
  - Dropping vld before acceptance is permitted; no transfer is recorded.
- Issue (registered, 1-cycle latency):
  - On a transfer from r at edge N: o_core_vld = 1 and o_core_data = i_req_data[r] for the cycle after edge N.
  - Tag r is pushed to the FIFO.
  - rr_ptr becomes (r+1) mod NUM_REQ.
  - With no transfer: o_core_vld = 0 and rr_ptr is held. o_core_data holds its last value.
- Return (registered, 1-cycle latency):
  - On i_core_vld with FIFO non-empty: pop tag t.
  - Next cycle: o_rsp_vld = one-hot(t), o_rsp_data = i_core_data.
  - Otherwise o_rsp_vld = 0.
  - Responses carry no backpressure; requesters must accept them.
- o_inflight:
  - +1 on transfer, -1 on a legal pop, unchanged when both occur.
  - Never exceeds MAX_OUTSTANDING.
- Errors:
  - i_core_vld with the FIFO empty sets o_err (sticky until reset). The result is dropped and o_rsp_vld stays 0. Counters are unchanged.
- Ordering: results are returned in issue order; the core is assumed in-order.
- Throughput: 1 op/cycle when the core accepts back-to-back, bounded by MAX_OUTSTANDING over the core latency.
- Reset mid-operation:
  - In-flight tags are discarded.
  - Any late core result after release with an empty FIFO sets o_err. This flags that the core was not co-reset.

Test Plan:
- Single request: requester 2 only, data 49'h1_0000_0000_1234 at cycle 0.
  - Required: rdy[2] = 1 in the same cycle; o_core_vld pulses 1 cycle later with that data.
  - Core returns 49'hABC.
  - Required: o_rsp_vld = 4'b0100 and o_rsp_data = 49'hABC one cycle after i_core_vld.
- Fairness: all 4 requesters hold vld continuously, stub core latency 2.
  - Required: grant order 0,1,2,3,0,1...
  - Required: each o_rsp_vld bit matches its issue order; no requester is granted twice before the others.
- Credit limit: MAX_OUTSTANDING = 4, core stubbed to never return.
  - Required: exactly 4 transfers, then all rdy = 0 and o_inflight = 4.
  - Inject one i_core_vld.
  - Required: in that same cycle exactly one new transfer is allowed; o_inflight stays 4.
- Simultaneous push/pop at full, sustained for 20 cycles.
  - Required: o_inflight stays constant.
  - Required: every result is routed to the correct owner; no o_err.
- Spurious return: i_core_vld = 1 with nothing in flight.
  - Required: o_err = 1 from the next cycle and stays set.
  - Required: o_rsp_vld = 0 and o_inflight = 0.
- Reset mid-flight: 3 ops in flight, assert i_rst_n low for 2 cycles.
  - Required: all outputs 0 immediately, rr_ptr = 0.
  - After release, the first request from requester 1 is granted with o_inflight = 0 → 1.
